// File: rtl/itch_msg_asm.sv
// itch_msg_asm: collects keep-qualified AXI beats from the MoldUDP64
// depacketiser into one ITCH message buffer. It emits the finished message as
// a one-cycle pulse, and length, keep, overrun and truncation faults as a
// one-cycle error pulse.
module itch_msg_asm #(
  parameter int AXI_DATA_W    = 64,
  parameter int AXI_KEEP_W    = AXI_DATA_W / 8,
  parameter int LEN           = 8,
  parameter int MSG_MAX_BYTES = 50,
  parameter int CNT_MAX       = (MSG_MAX_BYTES * LEN + AXI_DATA_W - 1) / AXI_DATA_W,
  parameter int CNT_MAX_W     = $clog2(CNT_MAX + 1),
  parameter int BYTE_CNT_W    = $clog2(CNT_MAX * AXI_KEEP_W + 1),
  parameter int MSG_W         = MSG_MAX_BYTES * LEN
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  mold_v_i,
  input  logic                  mold_start_i,
  input  logic [AXI_DATA_W-1:0] mold_data_i,
  input  logic [AXI_KEEP_W-1:0] mold_keep_i,
  input  logic [15:0]           mold_len_i,
  output logic                  itch_v_o,
  output logic [LEN-1:0]        itch_type_o,
  output logic [BYTE_CNT_W-1:0] itch_len_o,
  output logic [MSG_W-1:0]      itch_data_o,
  output logic                  itch_err_o
);

  localparam int SUM_W = BYTE_CNT_W + 1;

  typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

  function automatic logic [BYTE_CNT_W-1:0] popcount(input logic [AXI_KEEP_W-1:0] keep);
    logic [BYTE_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      cnt = cnt + BYTE_CNT_W'(keep[i]);
    end
    return cnt;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_v;
  logic                  r_err;
  logic [CNT_MAX_W-1:0]  r_beat_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [BYTE_CNT_W-1:0] r_len;
  logic [LEN-1:0]        r_buf [MSG_MAX_BYTES];

  logic                  w_v_nxt;
  logic                  w_err_nxt;
  logic [CNT_MAX_W-1:0]  w_beat_cnt_nxt;
  logic [BYTE_CNT_W-1:0] w_byte_cnt_nxt;
  logic [BYTE_CNT_W-1:0] w_len_nxt;
  logic                  w_wr0;
  logic                  w_wr_cont;
  logic [CNT_MAX-1:0]    w_beat_we;
  logic [BYTE_CNT_W-1:0] w_pop;
  logic [SUM_W-1:0]      w_sum;
  logic                  w_keep_ok;
  logic                  w_len_ok;

  // Keep must be non-empty and a run of ones starting at bit 0, so keep+1 clears every set bit.
  assign w_pop     = popcount(mold_keep_i);
  assign w_sum     = {1'b0, r_byte_cnt} + {1'b0, w_pop};
  assign w_keep_ok = (mold_keep_i != '0) &&
                     ((mold_keep_i & (mold_keep_i + AXI_KEEP_W'(1))) == '0);
  assign w_len_ok  = (mold_len_i != 16'd0) && (mold_len_i <= 16'(MSG_MAX_BYTES));

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counter updates, buffer write enables and output pulses for the current beat.
  always_comb begin
    w_state_nxt    = r_state;
    w_v_nxt        = 1'b0;
    w_err_nxt      = 1'b0;
    w_beat_cnt_nxt = r_beat_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_len_nxt      = r_len;
    w_wr0          = 1'b0;
    w_wr_cont      = 1'b0;
    if (mold_v_i) begin
      if (mold_start_i) begin
        if (!w_len_ok || !w_keep_ok) begin
          w_err_nxt      = 1'b1;
          w_state_nxt    = ST_IDLE;
          w_beat_cnt_nxt = '0;
          w_byte_cnt_nxt = '0;
        end else begin
          // A start while collecting truncates the old message; the new one proceeds.
          w_err_nxt      = (r_state == ST_COLLECT);
          w_wr0          = 1'b1;
          w_len_nxt      = mold_len_i[BYTE_CNT_W-1:0];
          w_beat_cnt_nxt = CNT_MAX_W'(1);
          w_byte_cnt_nxt = w_pop;
          if (16'(w_pop) >= mold_len_i) begin
            w_v_nxt     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_COLLECT;
          end
        end
      end else if (r_state == ST_COLLECT) begin
        if (!w_keep_ok || (r_beat_cnt >= CNT_MAX_W'(CNT_MAX))) begin
          w_err_nxt      = 1'b1;
          w_state_nxt    = ST_IDLE;
          w_beat_cnt_nxt = '0;
          w_byte_cnt_nxt = '0;
        end else begin
          w_wr_cont      = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt + CNT_MAX_W'(1);
          w_byte_cnt_nxt = w_sum[BYTE_CNT_W-1:0];
          if (w_sum >= {1'b0, r_len}) begin
            w_v_nxt     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_COLLECT;
          end
        end
      end else begin
        // Continuation outside a message is dropped silently.
        w_state_nxt = ST_IDLE;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Counters, latched length and registered pulses.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v        <= 1'b0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
      r_byte_cnt <= '0;
      r_len      <= '0;
    end else begin
      r_v        <= w_v_nxt;
      r_err      <= w_err_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_len      <= w_len_nxt;
    end
  end

  // Beat k owns buffer bytes [k*AXI_KEEP_W, (k+1)*AXI_KEEP_W).
  for (genvar k = 0; k < CNT_MAX; k++) begin : g_beat_we
    assign w_beat_we[k] = (k == 0) ? w_wr0
                                   : (w_wr_cont && (r_beat_cnt == CNT_MAX_W'(k)));
  end

  for (genvar n = 0; n < MSG_MAX_BYTES; n++) begin : g_byte
    // Message byte n is loaded from lane n mod AXI_KEEP_W of its beat.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_buf[n] <= '0;
      end else if (w_beat_we[n / AXI_KEEP_W]) begin
        r_buf[n] <= mold_data_i[LEN*(n % AXI_KEEP_W) +: LEN];
      end else begin
        r_buf[n] <= r_buf[n];
      end
    end
    assign itch_data_o[LEN*n +: LEN] = (r_len > BYTE_CNT_W'(n)) ? r_buf[n] : '0;
  end

  assign itch_v_o    = r_v;
  assign itch_err_o  = r_err;
  assign itch_len_o  = r_len;
  assign itch_type_o = r_buf[0];

endmodule

// File: tb/tb_itch_msg_asm.sv
// Self-checking bench for itch_msg_asm: a 64-bit and a 128-bit instance,
// directed scenarios plus randomized messages against a message-level model.
module tb_itch_msg_asm;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset;

  logic         a_v, a_start;
  logic [63:0]  a_data;
  logic [7:0]   a_keep;
  logic [15:0]  a_len;
  logic         a_iv, a_err;
  logic [7:0]   a_type;
  logic [5:0]   a_ilen;
  logic [399:0] a_idata;

  logic         b_v, b_start;
  logic [127:0] b_data;
  logic [15:0]  b_keep;
  logic [15:0]  b_len;
  logic         b_iv, b_err;
  logic [7:0]   b_type;
  logic [6:0]   b_ilen;
  logic [399:0] b_idata;

  itch_msg_asm #(.AXI_DATA_W(64)) dut64 (
    .clk(clk), .nreset(nreset), .mold_v_i(a_v), .mold_start_i(a_start),
    .mold_data_i(a_data), .mold_keep_i(a_keep), .mold_len_i(a_len),
    .itch_v_o(a_iv), .itch_type_o(a_type), .itch_len_o(a_ilen),
    .itch_data_o(a_idata), .itch_err_o(a_err));

  itch_msg_asm #(.AXI_DATA_W(128)) dut128 (
    .clk(clk), .nreset(nreset), .mold_v_i(b_v), .mold_start_i(b_start),
    .mold_data_i(b_data), .mold_keep_i(b_keep), .mold_len_i(b_len),
    .itch_v_o(b_iv), .itch_type_o(b_type), .itch_len_o(b_ilen),
    .itch_data_o(b_idata), .itch_err_o(b_err));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: message bytes placed by beat position, counted by keep.
  bit         m_collect;
  int         m_len, m_beats, m_cnt;
  logic [7:0] m_buf [64];

  bit           e_v, e_err;
  int           e_len;
  logic [7:0]   e_type;
  logic [399:0] e_data;
  logic         o_v, o_err;
  int           o_len;
  logic [7:0]   o_type;
  logic [399:0] o_data;

  task automatic beat(input bit wide, input bit st, input int len,
                      input logic [15:0] keep, input int typ);
    logic [127:0] data;
    logic [15:0]  km;
    int           pc, cmax, kw;
    bit           kok, acc;
    for (int i = 0; i < 4; i++) data[32*i +: 32] = $urandom;
    if (typ >= 0) data[7:0] = 8'(typ);
    kw   = wide ? 16 : 8;
    cmax = wide ? 4 : 7;
    km   = wide ? keep : {8'h00, keep[7:0]};
    pc   = $countones(km);
    kok  = (pc != 0) && (km == 16'((33'd1 << pc) - 33'd1));
    if (wide) begin
      b_v = 1'b1; b_start = st; b_data = data; b_keep = keep; b_len = 16'(len);
    end else begin
      a_v = 1'b1; a_start = st; a_data = data[63:0]; a_keep = keep[7:0]; a_len = 16'(len);
    end
    e_v = 1'b0; e_err = 1'b0; acc = 1'b0;
    if (st) begin
      e_err = m_collect;
      if (len < 1 || len > 50 || !kok) begin
        e_err = 1'b1; m_collect = 1'b0;
      end else begin
        m_len = len; m_beats = 0; m_cnt = 0; m_collect = 1'b1; acc = 1'b1;
      end
    end else if (m_collect) begin
      if (!kok || m_beats == cmax) begin
        e_err = 1'b1; m_collect = 1'b0;
      end else begin
        acc = 1'b1;
      end
    end
    if (acc) begin
      for (int l = 0; l < kw; l++)
        if (m_beats * kw + l < 50) m_buf[m_beats * kw + l] = data[8*l +: 8];
      m_beats++;
      m_cnt += pc;
      if (m_cnt >= m_len) begin
        e_v = 1'b1; m_collect = 1'b0;
      end
    end
    if (e_v) begin
      e_len = m_len; e_type = m_buf[0]; e_data = '0;
      for (int n = 0; n < m_len; n++) e_data[8*n +: 8] = m_buf[n];
    end
    @(posedge clk); #1;
    if (wide) begin
      o_v = b_iv; o_err = b_err; o_len = int'(b_ilen); o_type = b_type; o_data = b_idata;
    end else begin
      o_v = a_iv; o_err = a_err; o_len = int'(a_ilen); o_type = a_type; o_data = a_idata;
    end
    a_v = 1'b0; b_v = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    a_v = 1'b0; a_start = 1'b0; a_data = '0; a_keep = '0; a_len = '0;
    b_v = 1'b0; b_start = 1'b0; b_data = '0; b_keep = '0; b_len = '0;
    m_collect = 1'b0;
    #12;
    n_checks++;
    if ({a_iv, a_err, a_ilen, a_type} !== '0 || a_idata !== '0) begin
      n_errors++; $display("FAIL reset64: v=%b err=%b len=%0d type=%h required all 0", a_iv, a_err, a_ilen, a_type);
    end
    n_checks++;
    if ({b_iv, b_err, b_ilen, b_type} !== '0 || b_idata !== '0) begin
      n_errors++; $display("FAIL reset128: v=%b err=%b len=%0d type=%h required all 0", b_iv, b_err, b_ilen, b_type);
    end
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_order(input bit wide);
    logic [15:0] keeps [$];
    if (wide) keeps = '{16'hFFFF, 16'hFFFF, 16'h000F};
    else      keeps = '{16'hFF, 16'hFF, 16'hFF, 16'hFF, 16'h0F};
    foreach (keeps[i]) begin
      beat(wide, i == 0, 36, keeps[i], 8'h41);
      n_checks++;
      if (o_v !== e_v || o_err !== e_err || o_v !== (i == keeps.size() - 1)) begin
        n_errors++; $display("FAIL add_order w=%0d beat %0d: v/err=%b%b required %b%b", wide, i, o_v, o_err, e_v, e_err);
      end
      if (e_v) begin
        n_checks++;
        if (o_len !== 36 || o_type !== 8'h41 || o_data !== e_data) begin
          n_errors++; $display("FAIL add_order_data w=%0d: len=%0d type=%h required len=36 type=41", wide, o_len, o_type);
        end
      end
    end
  endtask

  task automatic test_system_event();
    for (int i = 0; i < 2; i++) begin
      beat(1'b0, i == 0, 12, 16'hFF, 8'h53);
      n_checks++;
      if (o_v !== e_v || o_err !== 1'b0) begin
        n_errors++; $display("FAIL system_event beat %0d: v/err=%b%b required %b0", i, o_v, o_err, e_v);
      end
      if (e_v) begin
        n_checks++;
        if (o_len !== 12 || o_type !== 8'h53 || o_data !== e_data || o_data[399:96] !== '0) begin
          n_errors++; $display("FAIL system_event_data: len=%0d type=%h required len=12 type=53", o_len, o_type);
        end
      end
    end
  endtask

  // Each table entry is {start, len, keep}.
  task automatic test_table(input string name, input logic [31:0] tbl [$]);
    foreach (tbl[i]) begin
      beat(1'b0, tbl[i][31], int'(tbl[i][23:16]), {8'h00, tbl[i][7:0]}, -1);
      n_checks++;
      if (o_v !== e_v || o_err !== e_err) begin
        n_errors++; $display("FAIL %s beat %0d: v/err=%b%b required %b%b", name, i, o_v, o_err, e_v, e_err);
      end
      if (e_v) begin
        n_checks++;
        if (o_len !== e_len || o_type !== e_type || o_data !== e_data) begin
          n_errors++; $display("FAIL %s_data beat %0d: len=%0d type=%h required len=%0d type=%h", name, i, o_len, o_type, e_len, e_type);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) beat(1'b0, i == 0, 36, 16'hFF, 8'h41);
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({a_iv, a_err, a_ilen, a_type} !== '0 || a_idata !== '0) begin
      n_errors++; $display("FAIL reset_mid: v=%b err=%b len=%0d type=%h required all 0", a_iv, a_err, a_ilen, a_type);
    end
    m_collect = 1'b0;
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_iv !== 1'b0 || a_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_quiet: v/err=%b%b required 00", a_iv, a_err);
    end
    test_add_order(1'b0);
  endtask

  task automatic test_random();
    int len, k, r, nb;
    logic [15:0] keep;
    for (int msg = 0; msg < 40; msg++) begin
      r = $urandom_range(0, 19);
      len = (r == 0) ? 0 : (r == 1) ? 51 + $urandom_range(0, 10) : $urandom_range(1, 50);
      nb = 0;
      do begin
        k = $urandom_range(1, 8);
        keep = 16'((17'd1 << k) - 17'd1);
        if ($urandom_range(0, 11) == 0) keep = 16'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk); #1;
          n_checks++;
          if (a_iv !== 1'b0 || a_err !== 1'b0) begin
            n_errors++; $display("FAIL random_gap msg %0d: v/err=%b%b required 00", msg, a_iv, a_err);
          end
        end
        beat(1'b0, nb == 0, len, keep, -1);
        nb++;
        n_checks++;
        if (o_v !== e_v || o_err !== e_err) begin
          n_errors++; $display("FAIL random msg %0d beat %0d: v/err=%b%b required %b%b", msg, nb, o_v, o_err, e_v, e_err);
        end
        if (e_v) begin
          n_checks++;
          if (o_len !== e_len || o_type !== e_type || o_data !== e_data) begin
            n_errors++; $display("FAIL random_data msg %0d: len=%0d type=%h required len=%0d type=%h", msg, o_len, o_type, e_len, e_type);
          end
        end
      end while (m_collect && nb < 10 && $urandom_range(0, 19) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_add_order(1'b0);
    test_system_event();
    test_table("truncation", '{{8'h80, 8'd36, 8'h00, 8'hFF}, {8'h00, 8'd0, 8'h00, 8'hFF},
                               {8'h80, 8'd12, 8'h00, 8'hFF}, {8'h00, 8'd0, 8'h00, 8'hFF}});
    test_table("bad_len", '{{8'h80, 8'd0, 8'h00, 8'hFF}, {8'h00, 8'd0, 8'h00, 8'hFF},
                            {8'h80, 8'd51, 8'h00, 8'hFF}, {8'h00, 8'd0, 8'h00, 8'hFF},
                            {8'h00, 8'd0, 8'h00, 8'hFF}});
    test_table("overrun", '{{8'h80, 8'd50, 8'h00, 8'h01}, {8'h00, 8'd0, 8'h00, 8'h01},
                            {8'h00, 8'd0, 8'h00, 8'h01}, {8'h00, 8'd0, 8'h00, 8'h01},
                            {8'h00, 8'd0, 8'h00, 8'h01}, {8'h00, 8'd0, 8'h00, 8'h01},
                            {8'h00, 8'd0, 8'h00, 8'h01}, {8'h00, 8'd0, 8'h00, 8'h01}});
    test_table("bad_keep", '{{8'h80, 8'd12, 8'h00, 8'hF5}, {8'h00, 8'd0, 8'h00, 8'hFF},
                             {8'h80, 8'd36, 8'h00, 8'hFF}, {8'h00, 8'd0, 8'h00, 8'h00},
                             {8'h80, 8'd12, 8'h00, 8'hFF}, {8'h00, 8'd0, 8'h00, 8'hF5}});
    test_table("back_to_back", '{{8'h80, 8'd5, 8'h00, 8'h1F}, {8'h80, 8'd12, 8'h00, 8'hFF},
                                 {8'h00, 8'd0, 8'h00, 8'hFF}, {8'h80, 8'd9, 8'h00, 8'hFF},
                                 {8'h00, 8'd0, 8'h00, 8'h01}, {8'h80, 8'd8, 8'h00, 8'hFF}});
    test_reset_mid();
    test_add_order(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/itch_msg_asm.md
# itch_msg_asm

Parametrised ITCH 5.0 message assembler between the MoldUDP64 depacketiser and the ITCH field decoders. It collects AXI-width data beats, with byte-granular keep, into one message buffer of up to MSG_MAX_BYTES bytes. It tracks the byte count against the message length from the Mold header and emits the complete message as a one-cycle pulse. Length, keep, overrun and truncation faults are reported on a single error pulse.

## Interface
- AXI_DATA_W, 64: beat data width in bits, multiple of 8.
- AXI_KEEP_W, AXI_DATA_W/8: keep width.
- LEN, 8: bits per byte.
- MSG_MAX_BYTES, 50: longest ITCH message in bytes.
- CNT_MAX, ceil(MSG_MAX_BYTES*LEN/AXI_DATA_W): maximum beats per message (7 at defaults).
- CNT_MAX_W, $clog2(CNT_MAX+1): beat counter width.
- BYTE_CNT_W, $clog2(CNT_MAX*AXI_KEEP_W+1): byte counter width.
- MSG_W, MSG_MAX_BYTES*LEN: output message width.

Ports:
- clk  in  1  clock; all flops on rising edge.
- nreset  in  1  reset, active-low, asynchronous; one clock, asynchronous active-low reset.
- mold_v_i  in  1  beat valid.
- mold_start_i  in  1  first beat of a message; only sampled when mold_v_i is high.
- mold_data_i  in  AXI_DATA_W  beat data; message byte n of the beat sits at bits [8n+7:8n].
- mold_keep_i  in  AXI_KEEP_W  byte enables; must be contiguous from bit 0.
- mold_len_i  in  16  message length in bytes from the Mold header; sampled on start beats only.
- itch_v_o  out  1  message complete; one-cycle pulse.
- itch_type_o  out  LEN  message byte 0.
- itch_len_o  out  BYTE_CNT_W  latched message length.
- itch_data_o  out  MSG_W  message bytes, byte 0 at LSB; bytes at or above itch_len_o read as 0.
- itch_err_o  out  1  error pulse, one cycle.

## Operation
- States are IDLE and COLLECT.
- The beat buffer is CNT_MAX registers. Beat k is written to buf[AXI_DATA_W*k +: AXI_DATA_W] when its enable fires.
  - Beat 0 write enable: mold_v_i & mold_start_i.
  - Beat k write enable: mold_v_i & ~mold_start_i & COLLECT & (beat_cnt_q == k).
- Start beat (any state):
  - Latch len_q = mold_len_i.
  - Set beat_cnt_q = 1 and byte_cnt_q = popcount(keep).
  - Go to COLLECT.
  - If the previous state was COLLECT, pulse itch_err_o to report the truncated message; the new message proceeds.
- Start with mold_len_i == 0 or mold_len_i > MSG_MAX_BYTES: pulse itch_err_o, stay in or return to IDLE, discard the beat.
- Continuation beat in COLLECT: beat_cnt_q += 1, byte_cnt_q += popcount(keep).
- Continuation beat in IDLE: ignored. No error and no write.
- Completion: the first beat where the post-add byte count is >= len_q.
  - Next cycle: itch_v_o = 1 and state returns to IDLE.
  - Bytes of that beat beyond len_q are discarded.
- Error events, each pulsing itch_err_o and returning to IDLE with no itch_v_o:
  - A beat would make beat_cnt_q exceed CNT_MAX before completion.
  - A valid beat has non-contiguous keep, or keep == 0.
- Output masking: itch_data_o = buf & mask(len_q), where byte n is passed only if n < len_q.
  - itch_type_o = buf[7:0].
- The buffer is not cleared on completion. Outputs hold the last message until the next start beat overwrites beat 0.
- Arithmetic: popcount is AXI_KEEP_W to BYTE_CNT_W bits. The byte sum is computed one bit wider, so it cannot wrap before the compare.

## Timing
- Reset values: itch_v_o = 0, itch_err_o = 0, itch_len_o = 0, itch_type_o = 0, itch_data_o = 0 (buffer reset to 0), state IDLE, counters 0.
- Latency: itch_v_o and itch_err_o are registered and assert exactly 1 cycle after the completing or offending beat.
- There is no backpressure. A beat is accepted every cycle that mold_v_i is high.
- A single-beat message completes on its start beat; itch_v_o follows on the next cycle.
- Back-to-back messages: a start beat in the cycle after the completing beat is accepted.
  - itch_v_o for the old message still pulses.
  - itch_data_o is valid only in the itch_v_o cycle when the next start overwrites beat 0.
- nreset assertion mid-message aborts asynchronously. No itch_v_o or itch_err_o is produced for the aborted message.
- Simultaneous start and completion are impossible. A start always opens a new message, and the prior COLLECT counts as truncated.

## Test plan
- Add Order 'A', len 36, 64-bit: 5 beats with keep FF,FF,FF,FF,0F -> itch_v_o 1 cycle after beat 5, itch_len_o = 36, itch_type_o = 0x41, bytes 36..49 = 0.
- System Event 'S', len 12: 2 beats with keep FF,FF -> itch_v_o after beat 2; bytes 12..15 discarded (read as 0); itch_err_o = 0.
- Truncation: start len 36, 2 beats, then a new start len 12 with 2 beats -> itch_err_o pulse 1 cycle after the second start, then itch_v_o for the len-12 message.
- Bad length: start with mold_len_i = 0, then with 51 -> itch_err_o pulse each time, state IDLE, following continuation beats ignored.
- Overrun and bad keep: len 50 with every beat keep 01 (8 beats) -> itch_err_o on beat 8. Separately, keep 0xF5 -> itch_err_o.
- Reset mid-message: nreset low after 3 beats of a len-36 message -> all outputs 0 immediately; the next start/complete sequence is unaffected; AXI_DATA_W = 128 rerun of the Add Order case completes after 3 beats.
